// File: rtl/cond_pkg.sv
// Shared types and constants for the condition/flag unit.
// Flag bus order: bit 0 = N, bit 1 = Z, bit 2 = C, bit 3 = V.
package cond_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against stored NZCV flags.
// The reserved encoding never passes.
module cond_check
    import cond_pkg::*;
#(
    parameter int unsigned P_FLAG_W = FLAG_W,
    parameter int unsigned P_COND_W = COND_W
) (
    input  logic [P_COND_W-1:0] cond,
    input  logic [P_FLAG_W-1:0] flags,
    output logic                cond_ex
);

    logic  w_n;
    logic  w_z;
    logic  w_c;
    logic  w_v;
    cond_e w_cond;

    assign w_n    = flags[FLAG_N];
    assign w_z    = flags[FLAG_Z];
    assign w_c    = flags[FLAG_C];
    assign w_v    = flags[FLAG_V];
    assign w_cond = cond_e'(cond[3:0]);

    always_comb begin
        cond_ex = 1'b0;
        case (w_cond)
            COND_EQ: cond_ex = w_z;
            COND_NE: cond_ex = ~w_z;
            COND_CS: cond_ex = w_c;
            COND_CC: cond_ex = ~w_c;
            COND_MI: cond_ex = w_n;
            COND_PL: cond_ex = ~w_n;
            COND_VS: cond_ex = w_v;
            COND_VC: cond_ex = ~w_v;
            COND_HI: cond_ex = w_c & ~w_z;
            COND_LS: cond_ex = ~w_c | w_z;
            COND_GE: cond_ex = (w_n == w_v);
            COND_LT: cond_ex = (w_n != w_v);
            COND_GT: cond_ex = ~w_z & (w_n == w_v);
            COND_LE: cond_ex = w_z | (w_n != w_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register plus condition-gated write strobes for the execute stage.
// Conditions always see the pre-update flags; updates appear one cycle later.
module cond_unit
    import cond_pkg::*;
#(
    parameter int unsigned P_FLAG_W = FLAG_W,
    parameter int unsigned P_COND_W = COND_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [P_COND_W-1:0] cond,
    input  logic [P_FLAG_W-1:0] alu_flags,
    input  logic [1:0]          flag_w,
    input  logic                reg_write,
    input  logic                mem_write,
    input  logic                pc_src,
    output logic                cond_ex,
    output logic                reg_write_g,
    output logic                mem_write_g,
    output logic                pc_src_g,
    output logic [P_FLAG_W-1:0] flags_q
);

    logic [P_FLAG_W-1:0] r_flags;
    logic [P_FLAG_W-1:0] w_flags_d;
    logic                w_cond_ex;
    logic                w_fire;

    cond_check #(
        .P_FLAG_W (P_FLAG_W),
        .P_COND_W (P_COND_W)
    ) u_cond_check (
        .cond    (cond),
        .flags   (r_flags),
        .cond_ex (w_cond_ex)
    );

    // An instruction commits only when it passes, is not stalled and not in reset.
    assign w_fire = w_cond_ex & ~stall & ~reset;

    // NZ and CV halves update independently so logic ops keep C and V.
    always_comb begin
        w_flags_d = r_flags;
        if (w_fire) begin
            if (flag_w[FW_NZ]) begin
                w_flags_d[FLAG_N] = alu_flags[FLAG_N];
                w_flags_d[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flag_w[FW_CV]) begin
                w_flags_d[FLAG_C] = alu_flags[FLAG_C];
                w_flags_d[FLAG_V] = alu_flags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_d;
        end
    end

    assign cond_ex     = w_cond_ex;
    assign reg_write_g = reg_write & w_fire;
    assign mem_write_g = mem_write & w_fire;
    assign pc_src_g    = pc_src & w_fire;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_cond_unit.sv
// Directed vector bench for cond_unit: table of single-cycle instructions
// followed by a full condition x flags sweep.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       reg_write;
    logic       mem_write;
    logic       pc_src;
    logic       cond_ex;
    logic       reg_write_g;
    logic       mem_write_g;
    logic       pc_src_g;
    logic [3:0] flags_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_w      (flag_w),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .pc_src      (pc_src),
        .cond_ex     (cond_ex),
        .reg_write_g (reg_write_g),
        .mem_write_g (mem_write_g),
        .pc_src_g    (pc_src_g),
        .flags_q     (flags_q)
    );

    typedef struct {
        logic       stall;
        logic       reset;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       rw;
        logic       mw;
        logic       pc;
        logic       ex;
        logic       rwg;
        logic       mwg;
        logic       pcg;
        logic [3:0] fq;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic golden(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[0]; z = f[1]; cc = f[2]; v = f[3];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic s, input logic r, input logic [3:0] c, input logic [3:0] a,
                         input logic [1:0] fw, input logic rw, input logic mw, input logic pc);
        stall = s; reset = r; cond = c; alu_flags = a; flag_w = fw;
        reg_write = rw; mem_write = mw; pc_src = pc;
    endtask

    initial begin
        //        stall rst cond     alu      fw     rw mw pc  ex rwg mwg pcg flags_after
        vecs[0]  = '{0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b0000};
        vecs[1]  = '{0, 0, 4'b1110, 4'b0000, 2'b00, 1, 0, 0,  1, 1, 0, 0, 4'b0000};
        vecs[2]  = '{0, 0, 4'b1110, 4'b0010, 2'b11, 0, 0, 0,  1, 0, 0, 0, 4'b0010};
        vecs[3]  = '{0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0,  1, 0, 0, 0, 4'b0010};
        vecs[4]  = '{0, 0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0,  0, 0, 0, 0, 4'b0010};
        vecs[5]  = '{0, 0, 4'b1110, 4'b1100, 2'b11, 0, 0, 0,  1, 0, 0, 0, 4'b1100};
        vecs[6]  = '{0, 0, 4'b1110, 4'b0001, 2'b10, 1, 0, 0,  1, 1, 0, 0, 4'b1101};
        vecs[7]  = '{0, 0, 4'b1011, 4'b0000, 2'b00, 0, 1, 1,  0, 0, 0, 0, 4'b1101};
        vecs[8]  = '{0, 0, 4'b1010, 4'b0000, 2'b00, 0, 1, 1,  1, 0, 1, 1, 4'b1101};
        vecs[9]  = '{0, 0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0,  1, 0, 0, 0, 4'b0000};
        vecs[10] = '{0, 0, 4'b0000, 4'b1111, 2'b11, 0, 1, 0,  0, 0, 0, 0, 4'b0000};
        vecs[11] = '{1, 0, 4'b1110, 4'b0101, 2'b11, 0, 0, 1,  1, 0, 0, 0, 4'b0000};
        vecs[12] = '{0, 0, 4'b1110, 4'b0101, 2'b11, 0, 0, 1,  1, 0, 0, 1, 4'b0101};
        vecs[13] = '{0, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1,  1, 0, 0, 0, 4'b0000};
        vecs[14] = '{0, 0, 4'b1110, 4'b1111, 2'b01, 0, 0, 0,  1, 0, 0, 0, 4'b1100};
        vecs[15] = '{0, 0, 4'b1111, 4'b1111, 2'b11, 1, 0, 0,  0, 0, 0, 0, 4'b1100};

        drive(0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_flags", flags_q, 4'b0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].reset, vecs[i].cond, vecs[i].alu, vecs[i].fw,
                  vecs[i].rw, vecs[i].mw, vecs[i].pc);
            #1;
            check($sformatf("v%0d_cond_ex", i), {3'b0, cond_ex}, {3'b0, vecs[i].ex});
            check($sformatf("v%0d_reg_write_g", i), {3'b0, reg_write_g}, {3'b0, vecs[i].rwg});
            check($sformatf("v%0d_mem_write_g", i), {3'b0, mem_write_g}, {3'b0, vecs[i].mwg});
            check($sformatf("v%0d_pc_src_g", i), {3'b0, pc_src_g}, {3'b0, vecs[i].pcg});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_flags_q", i), flags_q, vecs[i].fq);
        end

        for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            drive(0, 0, 4'b1110, 4'(f), 2'b11, 0, 0, 0);
            @(posedge clk);
            #1;
            check($sformatf("sweep_load_%0d", f), flags_q, 4'(f));
            for (int c = 0; c < 16; c++) begin
                drive(0, 0, 4'(c), 4'b0000, 2'b00, 1, 0, 0);
                #1;
                check($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, cond_ex},
                      {3'b0, golden(4'(c), 4'(f))});
                check($sformatf("sweep_rwg_c%0d_f%0d", c, f), {3'b0, reg_write_g},
                      {3'b0, golden(4'(c), 4'(f))});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer side of the ALU flag interface.
- Holds the architectural NZCV flag register.
- Evaluates the 4-bit ARM condition field of the current instruction against the stored flags.
- Gates the instruction's register-write, memory-write and PC-write strobes.
- Sits between the decoder/ALU and the register file, data memory and PC logic. It updates the flags from the ALU only when the instruction executes and requests a flag update.

Parameters:
- FLAG_W, 4, width of the flag bus.
- COND_W, 4, width of the condition field.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  when high, the flag register holds and all gated strobes are forced low.
- cond  input  COND_W  instruction condition field, bits [31:28].
- alu_flags  input  FLAG_W  ALU flags; bit 0 = N, bit 1 = Z, bit 2 = C, bit 3 = V.
- flag_w  input  2  flag write request; bit 1 = update N and Z, bit 0 = update C and V.
- reg_write  input  1  decoder register-write request.
- mem_write  input  1  decoder memory-write request.
- pc_src  input  1  decoder PC-write/branch request.
- cond_ex  output  1  the instruction passes its condition.
- reg_write_g  output  1  reg_write AND cond_ex AND NOT stall.
- mem_write_g  output  1  mem_write AND cond_ex AND NOT stall.
- pc_src_g  output  1  pc_src AND cond_ex AND NOT stall.
- flags_q  output  FLAG_W  current flag register, same bit order as alu_flags.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: flags_q = 4'b0000 on the first rising clk edge with reset high. While reset is high, all gated strobes are 0 regardless of inputs. cond_ex still reflects cond against flags_q.
- Condition evaluation is combinational from cond and flags_q (pre-update value). The instruction never sees its own ALU flags.
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111 is reserved: cond_ex = 0.
- Flag update at the rising clk edge when reset = 0, stall = 0 and cond_ex = 1:
  - if flag_w[1], then N,Z <= alu_flags[0], alu_flags[1];
  - if flag_w[0], then C,V <= alu_flags[2], alu_flags[3].
  - The two halves are independent. Logic ops request only bit 1, so C and V are retained.
- Failed condition (cond_ex = 0): no flag bits change, and all gated strobes are 0.
- Stall: flags hold and gated strobes are 0. cond_ex remains valid so the instruction can be re-evaluated on release.
- Reset with a pending update in the same cycle: reset wins and flags become 0.
- Latency: a flag update is visible on flags_q and cond_ex in the cycle after the write edge. Back-to-back flag-setting then conditional instructions see the updated flags, with no bypass.
- Gated outputs are purely combinational; there is no internal state besides the 4 flag bits.

Decomposition:
- Shared package cond_pkg:
  - cond_e enum with the 16 encodings (EQ..AL, NV);
  - flag index constants FLAG_N = 0, FLAG_Z = 1, FLAG_C = 2, FLAG_V = 3;
  - flag-write bit constants FW_NZ = 1, FW_CV = 0.
- One combinational sub-module, cond_check (inputs cond and flags; output cond_ex), instantiated by cond_unit. The flag register and gating logic stay in cond_unit.

Test Plan:
- Reset then cond = 0000, then cond = 1110 with reg_write = 1 -> flags_q = 0000; cond_ex = 0, then cond_ex = 1 with reg_write_g = 1.
- cond = 1110, flag_w = 11, alu_flags = 4'b0010 (Z = 1), clock -> flags_q = 0010. Next cycle EQ gives cond_ex = 1 and NE gives cond_ex = 0.
- Flags set to C = 1, V = 1 (4'b1100). Then AL logic op with flag_w = 10, alu_flags = 4'b0001 -> flags_q = 1101, with C and V retained. Then LT gives cond_ex = 0 (N = 1, V = 1), and GE gives 1.
- flags_q = 0000, cond = 0000 (fails), flag_w = 11, alu_flags = 1111, mem_write = 1 -> mem_write_g = 0 and flags_q stays 0000 after the edge.
- stall = 1 with cond = 1110, flag_w = 11, alu_flags = 0101, pc_src = 1 -> pc_src_g = 0, flags_q unchanged. Deassert stall -> update occurs on the next edge.
- Sweep all 16 cond values against all 16 flag values -> cond_ex matches the golden table; cond = 1111 is always 0. Also assert reset together with a valid update -> flags_q = 0000.
